// File: rtl/mvp_transform_sched.sv
// Streams a batch of vertices from vertex memory through a non-stallable 4x4 MVM
// and delivers the results through a small first-word fall-through FIFO.
module mvp_transform_sched #(
  parameter int DATAWIDTH  = 32,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               start,
  input  logic [3:0][3:0][DATAWIDTH-1:0]     mat,
  input  logic [ADDR_W-1:0]                  vtx_base,
  input  logic [ADDR_W-1:0]                  num_vertices,
  output logic                               vtx_rd_en,
  output logic [ADDR_W-1:0]                  vtx_addr,
  input  logic [3:0][DATAWIDTH-1:0]          vtx_data,
  output logic [3:0][3:0][DATAWIDTH-1:0]     mvm_A,
  output logic [3:0][DATAWIDTH-1:0]          mvm_x,
  output logic                               mvm_dv,
  input  logic [3:0][DATAWIDTH-1:0]          mvm_y,
  input  logic                               mvm_dv_out,
  output logic [3:0][DATAWIDTH-1:0]          o_vertex,
  output logic                               o_valid,
  input  logic                               o_ready,
  output logic                               busy,
  output logic                               done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]   OCC_LIMIT = FIFO_DEPTH[CNT_W:0];
  localparam logic [CNT_W-1:0] FIFO_FULL = FIFO_DEPTH[CNT_W-1:0];

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                           state_q, state_d;
  logic [3:0][3:0][DATAWIDTH-1:0]   mat_q, mat_d;
  logic [ADDR_W-1:0]                base_q, base_d;
  logic [ADDR_W-1:0]                num_q, num_d;
  logic [ADDR_W-1:0]                issued_q, issued_d;
  logic [CNT_W-1:0]                 in_flight_q, in_flight_d;
  logic [CNT_W-1:0]                 fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                 rd_ptr_q, rd_ptr_d;
  logic                             mvm_dv_q, mvm_dv_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;

  logic [3:0][DATAWIDTH-1:0]        fifo_mem [FIFO_DEPTH];
  logic [CNT_W:0]                   occupancy;
  logic                             fifo_push;
  logic                             fifo_pop;

  // Issue is throttled so every read in flight already owns a FIFO slot.
  assign occupancy = {1'b0, in_flight_q} + {1'b0, fifo_cnt_q};
  // Results with nothing in flight are leftovers from an aborted batch.
  assign fifo_push = mvm_dv_out && (in_flight_q != '0);
  assign o_valid   = (fifo_cnt_q != '0);
  assign fifo_pop  = o_valid && o_ready;
  assign o_vertex  = o_valid ? fifo_mem[rd_ptr_q] : '0;

  assign vtx_addr  = base_q + issued_q;
  assign mvm_A     = mat_q;
  assign mvm_x     = vtx_data;
  assign mvm_dv    = mvm_dv_q;
  assign busy      = busy_q;
  assign done      = done_q;

  always_comb begin
    state_d   = state_q;
    mat_d     = mat_q;
    base_d    = base_q;
    num_d     = num_q;
    issued_d  = issued_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    vtx_rd_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          mat_d    = mat;
          base_d   = vtx_base;
          num_d    = num_vertices;
          issued_d = '0;
          busy_d   = 1'b1;
          state_d  = (num_vertices == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        vtx_rd_en = (issued_q < num_q) && (occupancy < OCC_LIMIT);
        if (vtx_rd_en) begin
          issued_d = issued_q + ADDR_W'(1);
          if (issued_d == num_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (in_flight_q == '0 && fifo_cnt_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mvm_dv_d    = vtx_rd_en;
    in_flight_d = in_flight_q;
    fifo_cnt_d  = fifo_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    case ({vtx_rd_en, fifo_push})
      2'b10:   in_flight_d = in_flight_q + CNT_W'(1);
      2'b01:   in_flight_d = in_flight_q - CNT_W'(1);
      default: in_flight_d = in_flight_q;
    endcase
    case ({fifo_push, fifo_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    if (fifo_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (fifo_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      mat_q       <= '0;
      base_q      <= '0;
      num_q       <= '0;
      issued_q    <= '0;
      in_flight_q <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mvm_dv_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mat_q       <= mat_d;
      base_q      <= base_d;
      num_q       <= num_d;
      issued_q    <= issued_d;
      in_flight_q <= in_flight_d;
      fifo_cnt_q  <= fifo_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mvm_dv_q    <= mvm_dv_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr_q] <= mvm_y;
  end

  // The issue throttle guarantees space; a push into a full FIFO means a broken throttle.
  assert property (@(posedge clk) disable iff (!rstn) !(fifo_push && (fifo_cnt_q == FIFO_FULL)));

endmodule
